// File: rtl/modulo_counter.sv
// Up/down modulo-N counter stage for the stopwatch datapath: load/clear, lap capture, sticky wrap flag.
// Optional registered BCD output built only when MODULO_COUNTER_BCD_EN is defined.
module modulo_counter #(
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned MAX_VAL    = 99,
  parameter int unsigned BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_val,
  input  logic                    en,
  input  logic                    up,
  input  logic                    lap,
  input  logic                    ovf_clr,
  output logic [WIDTH-1:0]        count,
  output logic                    carry,
  output logic [WIDTH-1:0]        lap_val,
  output logic                    lap_valid,
  output logic                    ovf_sticky,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int unsigned     BCD_W = 4 * BCD_DIGITS;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  if ((MAX_VAL == 0) || (64'(MAX_VAL) >= (64'd1 << WIDTH))) begin : g_bad_max
    $fatal(1, "modulo_counter: MAX_VAL must satisfy 1 <= MAX_VAL < 2**WIDTH");
  end

  logic             wrap_c;
  logic [WIDTH-1:0] load_clamp;
  logic [WIDTH-1:0] count_nxt;

  // Next count: clr > load > en > hold
  always_comb begin
    load_clamp = (load_val > MAX_W) ? MAX_W : load_val;
    wrap_c     = up ? (count == MAX_W) : (count == '0);
    count_nxt  = count;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_clamp;
    end else if (en) begin
      if (up) begin
        count_nxt = (count == MAX_W) ? '0 : count + WIDTH'(1);
      end else begin
        count_nxt = (count == '0) ? MAX_W : count - WIDTH'(1);
      end
    end
  end

  // Same-cycle cascade pulse so the next stage steps on this edge
  assign carry = en & ~clr & ~load & ~rst & wrap_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      lap_val    <= '0;
      lap_valid  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count     <= count_nxt;
      lap_valid <= lap;
      if (lap) begin
        lap_val <= count;
      end
      if (carry) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

`ifdef MODULO_COUNTER_BCD_EN
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned k = 0; k < n; k++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam longint unsigned BCD_SPAN = pow10(BCD_DIGITS);

  if (BCD_SPAN <= 64'(MAX_VAL)) begin : g_bad_bcd
    $fatal(1, "modulo_counter: BCD_DIGITS too small for MAX_VAL");
  end

  logic [BCD_W-1:0] bcd_nxt;

  // Shift-and-add-3 conversion of the current count
  always_comb begin
    bcd_nxt = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
        if (bcd_nxt[4*d +: 4] >= 4'd5) begin
          bcd_nxt[4*d +: 4] = bcd_nxt[4*d +: 4] + 4'd3;
        end
      end
      bcd_nxt = {bcd_nxt[BCD_W-2:0], count[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd <= '0;
    end else begin
      bcd <= bcd_nxt;
    end
  end
`else
  assign bcd = '0;
`endif

endmodule

// File: tb/tb_modulo_counter.sv
// Bench for modulo_counter: directed vector table, hand-written reset/BCD sequences,
// then random stimulus against an arithmetic reference model.
module tb_modulo_counter;

  localparam int unsigned WIDTH      = 7;
  localparam int unsigned MAX_VAL    = 99;
  localparam int unsigned BCD_DIGITS = 3;
  localparam int          NTBL       = 23;

  logic                    clk;
  logic                    rst;
  logic                    clr;
  logic                    load;
  logic [WIDTH-1:0]        load_val;
  logic                    en;
  logic                    up;
  logic                    lap;
  logic                    ovf_clr;
  logic [WIDTH-1:0]        count;
  logic                    carry;
  logic [WIDTH-1:0]        lap_val;
  logic                    lap_valid;
  logic                    ovf_sticky;
  logic [4*BCD_DIGITS-1:0] bcd;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_count, m_lap, m_bcd;
  bit m_lapv, m_ovf;

  typedef struct {
    bit clr;
    bit load;
    int lv;
    bit en;
    bit up;
    bit lap;
    bit oc;
    bit e_carry;
    int e_count;
    bit e_lapv;
    int e_lap;
    bit e_ovf;
  } vec_t;

  vec_t tbl [NTBL];

  modulo_counter #(
    .WIDTH      (WIDTH),
    .MAX_VAL    (MAX_VAL),
    .BCD_DIGITS (BCD_DIGITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .up         (up),
    .lap        (lap),
    .ovf_clr    (ovf_clr),
    .count      (count),
    .carry      (carry),
    .lap_val    (lap_val),
    .lap_valid  (lap_valid),
    .ovf_sticky (ovf_sticky),
    .bcd        (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bcd_of(input int v);
    int r;
    int x;
    r = 0;
    x = v;
`ifdef MODULO_COUNTER_BCD_EN
    for (int k = 0; k < int'(BCD_DIGITS); k++) begin
      r = r | ((x % 10) << (4 * k));
      x = x / 10;
    end
`endif
    return r;
  endfunction

  function automatic bit model_carry();
    if (rst || !en || clr || load) return 1'b0;
    return up ? (m_count == int'(MAX_VAL)) : (m_count == 0);
  endfunction

  task automatic model_reset();
    m_count = 0;
    m_lap   = 0;
    m_lapv  = 1'b0;
    m_ovf   = 1'b0;
    m_bcd   = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    bit c;
    int n;
    if (rst) begin
      model_reset();
    end else begin
      c = model_carry();
      n = m_count;
      if (clr)            n = 0;
      else if (load)      n = (int'(load_val) > int'(MAX_VAL)) ? int'(MAX_VAL) : int'(load_val);
      else if (en && up)  n = (m_count + 1) % (int'(MAX_VAL) + 1);
      else if (en)        n = (m_count + int'(MAX_VAL)) % (int'(MAX_VAL) + 1);
      if (lap) m_lap = m_count;
      m_lapv = lap;
      m_bcd  = bcd_of(m_count);
      if (c)            m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_count = n;
    end
  endtask

  task automatic drive(input bit c, input bit l, input int lv, input bit e,
                       input bit u, input bit lp, input bit oc);
    clr      = c;
    load     = l;
    load_val = WIDTH'(lv);
    en       = e;
    up       = u;
    lap      = lp;
    ovf_clr  = oc;
  endtask

  // One cycle: inputs already driven; checks carry before edge, returns after edge+1
  task automatic cycle(input string tag, input int exp_carry);
    #1;
    check({tag, " carry"}, int'(carry), exp_carry);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_regs(input string tag, input int e_count, input int e_lapv,
                            input int e_lap, input int e_ovf);
    check({tag, " count"}, int'(count), e_count);
    check({tag, " lap_valid"}, int'(lap_valid), e_lapv);
    check({tag, " lap_val"}, int'(lap_val), e_lap);
    check({tag, " ovf_sticky"}, int'(ovf_sticky), e_ovf);
    check({tag, " bcd"}, int'(bcd), m_bcd);
  endtask

  initial begin
    //             clr ld lv  en up lap oc | carry cnt lapv lap ovf
    tbl[0]  = '{0, 1, 98,  0, 1, 0, 0,  0, 98, 0, 0,  0};
    tbl[1]  = '{0, 0, 0,   1, 1, 0, 0,  0, 99, 0, 0,  0};
    tbl[2]  = '{0, 0, 0,   1, 1, 0, 0,  1, 0,  0, 0,  1};
    tbl[3]  = '{0, 0, 0,   1, 1, 0, 0,  0, 1,  0, 0,  1};
    tbl[4]  = '{1, 0, 0,   0, 0, 0, 0,  0, 0,  0, 0,  1};
    tbl[5]  = '{0, 0, 0,   1, 0, 0, 0,  1, 99, 0, 0,  1};
    tbl[6]  = '{0, 0, 0,   0, 0, 0, 1,  0, 99, 0, 0,  0};
    tbl[7]  = '{0, 0, 0,   1, 1, 0, 1,  1, 0,  0, 0,  1};
    tbl[8]  = '{0, 0, 0,   1, 0, 0, 0,  1, 99, 0, 0,  1};
    tbl[9]  = '{1, 0, 0,   0, 0, 0, 1,  0, 0,  0, 0,  0};
    tbl[10] = '{0, 1, 120, 0, 0, 0, 0,  0, 99, 0, 0,  0};
    tbl[11] = '{1, 1, 5,   1, 1, 0, 0,  0, 0,  0, 0,  0};
    tbl[12] = '{0, 1, 50,  1, 0, 0, 0,  0, 50, 0, 0,  0};
    tbl[13] = '{0, 1, 57,  0, 0, 0, 0,  0, 57, 0, 0,  0};
    tbl[14] = '{0, 0, 0,   1, 1, 1, 0,  0, 58, 1, 57, 0};
    tbl[15] = '{0, 0, 0,   0, 0, 0, 0,  0, 58, 0, 57, 0};
    tbl[16] = '{0, 0, 0,   1, 1, 1, 0,  0, 59, 1, 58, 0};
    tbl[17] = '{0, 0, 0,   1, 1, 1, 0,  0, 60, 1, 59, 0};
    tbl[18] = '{0, 1, 99,  0, 0, 1, 0,  0, 99, 1, 60, 0};
    tbl[19] = '{0, 0, 0,   1, 1, 1, 0,  1, 0,  1, 99, 1};
    tbl[20] = '{0, 0, 0,   0, 0, 0, 0,  0, 0,  0, 99, 1};
    tbl[21] = '{0, 1, 10,  0, 0, 0, 0,  0, 10, 0, 99, 1};
    tbl[22] = '{1, 0, 0,   0, 0, 1, 0,  0, 0,  1, 10, 1};

    // Reset state; en/down would wrap from 0 if rst did not gate carry
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset carry", int'(carry), 0);
    check_regs("reset", 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Directed vector table
    for (int i = 0; i < NTBL; i++) begin
      drive(tbl[i].clr, tbl[i].load, tbl[i].lv, tbl[i].en, tbl[i].up, tbl[i].lap, tbl[i].oc);
      cycle($sformatf("tbl%0d", i), int'(tbl[i].e_carry));
      check_regs($sformatf("tbl%0d", i), tbl[i].e_count, int'(tbl[i].e_lapv),
                 tbl[i].e_lap, int'(tbl[i].e_ovf));
    end

    // Asynchronous reset between edges at count 42
    drive(0, 1, 41, 0, 0, 0, 0);
    cycle("pre42a", 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    cycle("pre42b", 0);
    check("pre42 count", int'(count), 42);
    drive(0, 0, 0, 1, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async rst carry", int'(carry), 0);
    check_regs("async rst", 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    drive(0, 0, 0, 1, 1, 0, 0);
    @(posedge clk);
    model_edge();
    #1;
    check("post rst count", int'(count), 1);

    // BCD follows count one cycle later
    drive(0, 1, 57, 0, 0, 0, 0);
    cycle("bcd load", 0);
    check("bcd load count", int'(count), 57);
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle("bcd hold", 0);
`ifdef MODULO_COUNTER_BCD_EN
    check("bcd 57", int'(bcd), 'h057);
`else
    check("bcd off", int'(bcd), 0);
`endif

    // Random stimulus against the reference model
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 127)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0);
      cycle($sformatf("rnd%0d", n), int'(model_carry()));
      check_regs($sformatf("rnd%0d", n), m_count, int'(m_lapv), m_lap, int'(m_ovf));
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
